move_applier: RTL and testbench

- Downstream of the move planner. Consumes each planned `direction`/`direction_valid` pair and commits the move into the shared board memory.
- Board memory holds one byte per node; bit k set means edge k from that node has been drawn.
- For a legal move the block sets the source-edge bit and the opposite-edge bit at the destination node, then reports the new ball position and whether the same player moves again (bounce).

---
 rtl/move_applier_pkg.sv | 29 ++
 rtl/move_applier_dir_delta.sv | 30 +++
 rtl/move_applier.sv | 166 ++++++++++++++++
 tb/tb_move_applier.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/move_applier_pkg.sv
// Shared definitions for the move applier: board geometry widths,
// direction codes and the commit FSM state encoding.
package move_applier_pkg;

  localparam int COORD_W = 8;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 8;

  localparam logic [2:0] DIR_N  = 3'd0;
  localparam logic [2:0] DIR_NE = 3'd1;
  localparam logic [2:0] DIR_E  = 3'd2;
  localparam logic [2:0] DIR_SE = 3'd3;
  localparam logic [2:0] DIR_S  = 3'd4;
  localparam logic [2:0] DIR_SW = 3'd5;
  localparam logic [2:0] DIR_W  = 3'd6;
  localparam logic [2:0] DIR_NW = 3'd7;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_SRC   = 3'd1,
    WAIT_SRC = 3'd2,
    WR_SRC   = 3'd3,
    RD_DST   = 3'd4,
    WAIT_DST = 3'd5,
    WR_DST   = 3'd6,
    DONE     = 3'd7
  } state_e;

endpackage

// File: rtl/move_applier_dir_delta.sv
// Direction code to unit step and reverse direction; north is y-1.
// Shared with the planner decode and the display path.
module move_applier_dir_delta
  import move_applier_pkg::*;
(
  input  logic              [2:0] direction,
  output logic signed       [1:0] dx,
  output logic signed       [1:0] dy,
  output logic              [2:0] opposite
);

  // Decode the step for each of the eight compass directions.
  always_comb begin
    dx       = 2'sd0;
    dy       = 2'sd0;
    opposite = direction ^ 3'd4;
    case (direction)
      DIR_N:   begin dx = 2'sd0;  dy = -2'sd1; end
      DIR_NE:  begin dx = 2'sd1;  dy = -2'sd1; end
      DIR_E:   begin dx = 2'sd1;  dy = 2'sd0;  end
      DIR_SE:  begin dx = 2'sd1;  dy = 2'sd1;  end
      DIR_S:   begin dx = 2'sd0;  dy = 2'sd1;  end
      DIR_SW:  begin dx = -2'sd1; dy = 2'sd1;  end
      DIR_W:   begin dx = -2'sd1; dy = 2'sd0;  end
      DIR_NW:  begin dx = -2'sd1; dy = -2'sd1; end
      default: begin dx = 2'sd0;  dy = 2'sd0;  end
    endcase
  end

endmodule

// File: rtl/move_applier.sv
// Commits one planned move into board memory: marks the edge at the source
// and the reverse edge at the destination, then reports position and bounce.
module move_applier
  import move_applier_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         direction,
  input  logic               direction_valid,
  input  logic [COORD_W-1:0] current_x,
  input  logic [COORD_W-1:0] current_y,
  input  logic [COORD_W-1:0] width,
  input  logic [COORD_W-1:0] length,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd_en,
  input  logic [DATA_W-1:0]  mem_rd_data,
  output logic               mem_wr_en,
  output logic [DATA_W-1:0]  mem_wr_data,
  output logic               busy,
  output logic               done,
  output logic               move_ok,
  output logic               another_move,
  output logic [COORD_W-1:0] new_x,
  output logic [COORD_W-1:0] new_y
);

  state_e                    state_r, state_nx_s;
  logic [2:0]                dir_r, delta_dir_s, opp_s;
  logic [COORD_W-1:0]        src_x_r, src_y_r, dst_x_r, dst_y_r, width_r, length_r;
  logic signed [1:0]         dx_s, dy_s;
  logic signed [COORD_W:0]   dst_x_s, dst_y_s;
  logic                      in_range_s, accept_s, edge_used_s, border_s;
  logic [DATA_W-1:0]         dir_bit_s, opp_bit_s;
  logic [ADDR_W-1:0]         src_addr_s, dst_addr_s;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [COORD_W-1:0] x,
                                                   input logic [COORD_W-1:0] y,
                                                   input logic [COORD_W-1:0] w);
    logic [2*COORD_W-1:0] prod_s;
    prod_s = (2*COORD_W)'(w) * (2*COORD_W)'(y);
    return ADDR_W'(prod_s) + ADDR_W'(x);
  endfunction

  // Before acceptance the live input drives the decoder, afterwards the latched code.
  assign delta_dir_s = (state_r == IDLE) ? direction : dir_r;

  move_applier_dir_delta u_dir_delta (
    .direction (delta_dir_s),
    .dx        (dx_s),
    .dy        (dy_s),
    .opposite  (opp_s)
  );

  // Destination, bounds, edge masks and addresses.
  always_comb begin
    dst_x_s     = $signed({1'b0, current_x}) + (COORD_W+1)'(dx_s);
    dst_y_s     = $signed({1'b0, current_y}) + (COORD_W+1)'(dy_s);
    in_range_s  = ~dst_x_s[COORD_W] & ~dst_y_s[COORD_W]
                & (dst_x_s[COORD_W-1:0] < width) & (dst_y_s[COORD_W-1:0] < length);
    accept_s    = (state_r == IDLE) & direction_valid;
    dir_bit_s   = DATA_W'(1'b1) << dir_r;
    opp_bit_s   = DATA_W'(1'b1) << opp_s;
    edge_used_s = |(mem_rd_data & dir_bit_s);
    border_s    = (dst_x_r == COORD_W'(1'b0)) | (dst_x_r == width_r - COORD_W'(1'b1))
                | (dst_y_r == COORD_W'(1'b0)) | (dst_y_r == length_r - COORD_W'(1'b1));
    src_addr_s  = (state_r == IDLE) ? cell_addr(current_x, current_y, width)
                                    : cell_addr(src_x_r, src_y_r, width_r);
    dst_addr_s  = cell_addr(dst_x_r, dst_y_r, width_r);
  end

  // Next-state decode of the read-modify-write sequence.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (direction_valid) begin
          state_nx_s = in_range_s ? RD_SRC : DONE;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RD_SRC:   state_nx_s = WAIT_SRC;
      WAIT_SRC: begin
        if (edge_used_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = WR_SRC;
        end
      end
      WR_SRC:   state_nx_s = RD_DST;
      RD_DST:   state_nx_s = WAIT_DST;
      WAIT_DST: state_nx_s = WR_DST;
      WR_DST:   state_nx_s = DONE;
      DONE:     state_nx_s = IDLE;
      default:  state_nx_s = IDLE;
    endcase
  end

  // State register, latched move context and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      dir_r        <= 3'd0;
      src_x_r      <= '0;
      src_y_r      <= '0;
      dst_x_r      <= '0;
      dst_y_r      <= '0;
      width_r      <= '0;
      length_r     <= '0;
      mem_addr     <= '0;
      mem_rd_en    <= 1'b0;
      mem_wr_en    <= 1'b0;
      mem_wr_data  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      move_ok      <= 1'b0;
      another_move <= 1'b0;
      new_x        <= '0;
      new_y        <= '0;
    end else begin
      state_r   <= state_nx_s;
      busy      <= (state_nx_s != IDLE);
      done      <= (state_nx_s == DONE);
      mem_rd_en <= (state_nx_s == RD_SRC) || (state_nx_s == RD_DST);
      mem_wr_en <= (state_nx_s == WR_SRC) || (state_nx_s == WR_DST);
      case (state_nx_s)
        RD_SRC, WR_SRC: mem_addr <= src_addr_s;
        RD_DST, WR_DST: mem_addr <= dst_addr_s;
        default:        mem_addr <= '0;
      endcase
      case (state_nx_s)
        WR_SRC:  mem_wr_data <= mem_rd_data | dir_bit_s;
        WR_DST:  mem_wr_data <= mem_rd_data | opp_bit_s;
        default: mem_wr_data <= '0;
      endcase
      if (accept_s) begin
        dir_r        <= direction;
        src_x_r      <= current_x;
        src_y_r      <= current_y;
        dst_x_r      <= dst_x_s[COORD_W-1:0];
        dst_y_r      <= dst_y_s[COORD_W-1:0];
        width_r      <= width;
        length_r     <= length;
        move_ok      <= 1'b0;
        another_move <= 1'b0;
      end else if (state_r == WAIT_DST) begin
        another_move <= (mem_rd_data != '0) | border_s;
      end
      // A rejected move reports the unchanged position.
      if (state_nx_s == DONE) begin
        move_ok <= (state_r == WR_DST);
        if (state_r == WR_DST) begin
          new_x <= dst_x_r;
          new_y <= dst_y_r;
        end else if (state_r == IDLE) begin
          new_x <= current_x;
          new_y <= current_y;
        end else begin
          new_x <= src_x_r;
          new_y <= src_y_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_move_applier.sv
// Directed bench for move_applier with a registered-read board memory model.
module tb_move_applier;
  import move_applier_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic [2:0] direction;
  logic direction_valid;
  logic [7:0] current_x, current_y, width, length;
  logic [15:0] mem_addr;
  logic mem_rd_en, mem_wr_en;
  logic [7:0] mem_rd_data, mem_wr_data;
  logic busy, done, move_ok, another_move;
  logic [7:0] new_x, new_y;

  logic [7:0]  mem [65536];
  logic        pl_en = 1'b0;
  logic        clr_req = 1'b0;
  logic [15:0] pl_addr = 16'd0;
  logic [7:0]  pl_data = 8'd0;
  int          wr_cnt = 0;
  logic [15:0] wr_addr_log [64];
  logic [7:0]  wr_data_log [64];
  int          done_cnt = 0;
  logic        excl_bad = 1'b0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  move_applier dut (
    .clk(clk), .rst(rst), .direction(direction), .direction_valid(direction_valid),
    .current_x(current_x), .current_y(current_y), .width(width), .length(length),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data), .busy(busy), .done(done),
    .move_ok(move_ok), .another_move(another_move), .new_x(new_x), .new_y(new_y)
  );

  // Board memory: one-cycle read latency, write log for checking.
  always @(posedge clk) begin
    if (clr_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end
    if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
      wr_addr_log[6'(wr_cnt)] <= mem_addr;
      wr_data_log[6'(wr_cnt)] <= mem_wr_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
  end

  // Done pulse counter and strobe/address exclusivity monitor.
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if ((mem_rd_en && mem_wr_en) || (!mem_rd_en && !mem_wr_en && mem_addr != 16'd0))
      excl_bad <= 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    @(negedge clk); clr_req = 1'b1;
    @(negedge clk); clr_req = 1'b0;
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk); pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(negedge clk); pl_en = 1'b0;
  endtask

  // Issue one move; lat = cycles from accept to the done pulse (0 = no pulse within 20 cycles).
  task automatic run_move(input logic [2:0] d, input logic [7:0] x, input logic [7:0] y,
                          output int lat);
    @(negedge clk);
    direction = d; current_x = x; current_y = y; direction_valid = 1'b1;
    @(posedge clk); #1 direction_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin lat = i; break; end
    end
  endtask

  int lat, base, d0;

  initial begin
    rst = 1'b1; direction = 3'd0; direction_valid = 1'b0;
    current_x = 8'd0; current_y = 8'd0; width = 8'd9; length = 8'd13;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 32'({busy, done, move_ok, another_move, mem_rd_en, mem_wr_en}), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wr_data), 32'd0);
    chk("rst_new", 32'({new_x, new_y}), 32'd0);
    rst = 1'b0;

    // Legal move north, no bounce
    clear_mem(); base = wr_cnt;
    run_move(DIR_N, 8'd4, 8'd6, lat);
    chk("t1_lat", 32'(lat), 32'd7);
    chk("t1_ok_bounce", 32'({move_ok, another_move}), 32'b10);
    chk("t1_new", 32'({new_x, new_y}), {16'd0, 8'd4, 8'd5});
    chk("t1_busy_at_done", 32'(busy), 32'd1);
    chk("t1_nwr", 32'(wr_cnt - base), 32'd2);
    chk("t1_wr0", 32'({wr_addr_log[6'(base)], wr_data_log[6'(base)]}), {8'd0, 16'd58, 8'h01});
    chk("t1_wr1", 32'({wr_addr_log[6'(base+1)], wr_data_log[6'(base+1)]}), {8'd0, 16'd49, 8'h10});
    @(negedge clk);
    chk("t1_after", 32'({busy, done, move_ok}), 32'b001);

    // Bounce on a visited node
    clear_mem(); preload(16'd49, 8'h02); base = wr_cnt;
    run_move(DIR_N, 8'd4, 8'd6, lat);
    chk("t2_lat", 32'(lat), 32'd7);
    chk("t2_ok_bounce", 32'({move_ok, another_move}), 32'b11);
    chk("t2_wr1", 32'({wr_addr_log[6'(base+1)], wr_data_log[6'(base+1)]}), {8'd0, 16'd49, 8'h12});

    // Border bounce moving west onto column 0
    clear_mem(); base = wr_cnt;
    run_move(DIR_W, 8'd1, 8'd6, lat);
    chk("t3_ok_bounce", 32'({move_ok, another_move}), 32'b11);
    chk("t3_new", 32'({new_x, new_y}), {16'd0, 8'd0, 8'd6});
    chk("t3_wr0", 32'({wr_addr_log[6'(base)], wr_data_log[6'(base)]}), {8'd0, 16'd55, 8'h40});
    chk("t3_wr1", 32'({wr_addr_log[6'(base+1)], wr_data_log[6'(base+1)]}), {8'd0, 16'd54, 8'h04});

    // Border bounce moving south onto the last row
    clear_mem(); base = wr_cnt;
    run_move(DIR_S, 8'd4, 8'd11, lat);
    chk("t4_ok_bounce", 32'({move_ok, another_move}), 32'b11);
    chk("t4_wr0", 32'({wr_addr_log[6'(base)], wr_data_log[6'(base)]}), {8'd0, 16'd103, 8'h10});
    chk("t4_wr1", 32'({wr_addr_log[6'(base+1)], wr_data_log[6'(base+1)]}), {8'd0, 16'd112, 8'h01});

    // Bounds reject off the top-left corner
    clear_mem(); base = wr_cnt;
    run_move(DIR_NW, 8'd0, 8'd0, lat);
    chk("t5_lat", 32'(lat), 32'd1);
    chk("t5_ok_bounce", 32'({move_ok, another_move}), 32'b00);
    chk("t5_new", 32'({new_x, new_y}), 32'd0);
    @(negedge clk);
    chk("t5_nwr_busy", 32'({wr_cnt - base, 31'(busy)}), 32'd0);

    // Bounds reject off the right edge (x == width)
    run_move(DIR_E, 8'd8, 8'd12, lat);
    chk("t6_lat_ok", 32'({lat[30:0], move_ok}), {31'd1, 1'b0});
    chk("t6_new", 32'({new_x, new_y}), {16'd0, 8'd8, 8'd12});

    // Used-edge reject
    clear_mem(); preload(16'd58, 8'h04); base = wr_cnt;
    run_move(DIR_E, 8'd4, 8'd6, lat);
    chk("t7_lat", 32'(lat), 32'd3);
    chk("t7_ok", 32'(move_ok), 32'd0);
    chk("t7_new", 32'({new_x, new_y}), {16'd0, 8'd4, 8'd6});
    repeat (4) @(negedge clk);
    chk("t7_nwr", 32'(wr_cnt - base), 32'd0);

    // direction_valid pulsed while busy is ignored
    clear_mem(); base = wr_cnt;
    @(posedge clk); #1 d0 = done_cnt;
    @(negedge clk);
    direction = DIR_N; current_x = 8'd4; current_y = 8'd6; direction_valid = 1'b1;
    @(posedge clk); #1 direction_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    direction = DIR_E; direction_valid = 1'b1;
    @(negedge clk); direction_valid = 1'b0;
    repeat (15) @(negedge clk);
    @(posedge clk); #1;
    chk("r1_dones", 32'(done_cnt - d0), 32'd1);
    chk("r1_nwr", 32'(wr_cnt - base), 32'd2);
    chk("r1_wr1", 32'({wr_addr_log[6'(base+1)], wr_data_log[6'(base+1)]}), {8'd0, 16'd49, 8'h10});

    // Reset during the source write
    clear_mem(); base = wr_cnt;
    @(posedge clk); #1 d0 = done_cnt;
    @(negedge clk);
    direction = DIR_N; current_x = 8'd4; current_y = 8'd6; direction_valid = 1'b1;
    @(posedge clk); #1 direction_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    chk("r2_in_wr_src", 32'({mem_wr_en, mem_addr}), {15'd0, 1'b1, 16'd58});
    @(posedge clk); #1 rst = 1'b0;
    chk("r2_idle", 32'({busy, done, mem_wr_en, mem_rd_en, move_ok}), 32'd0);
    repeat (10) @(negedge clk);
    chk("r2_nwr", 32'(wr_cnt - base), 32'd1);
    chk("r2_src_kept", 32'(mem[58]), 32'h01);
    chk("r2_dst_untouched", 32'(mem[49]), 32'h00);
    chk("r2_no_done", 32'(done_cnt - d0), 32'd0);

    chk("strobe_excl", 32'(excl_bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
